c15xx_sd_arbiter: RTL and testbench

- Parametrised multi-drive successor of the single-drive SD glue. Shares one MiSTer SD block port among NDRIVES drive instances (c1541/c1571 track buffers), granting one sector transfer at a time, round-robin.
- Also owns each drive's disk-change / write-protect handling: read-only latch plus change-hold pulse.
- Sits between the drive instances and hps_io, in the clk_sys domain.

---
 rtl/c15xx_sd_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_c15xx_sd_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c15xx_sd_arbiter.sv
// Round-robin arbiter sharing one hps_io SD block port among NDRIVES drive channels.
// Also owns per-drive disk-change hold pulses and read-only latches that feed drv_wps_n.
module c15xx_sd_arbiter #(
   parameter int unsigned NDRIVES  = 4,
   parameter int unsigned CHG_HOLD = 15000000
) (
   input  logic                    clk_sys,
   input  logic                    reset,

   input  logic [32*NDRIVES-1:0]   drv_lba,
   input  logic [NDRIVES-1:0]      drv_rd,
   input  logic [NDRIVES-1:0]      drv_wr,
   output logic [NDRIVES-1:0]      drv_ack,
   output logic [NDRIVES-1:0]      drv_buff_wr,
   input  logic [8*NDRIVES-1:0]    drv_buff_din,

   output logic [31:0]             sd_lba,
   output logic                    sd_rd,
   output logic                    sd_wr,
   input  logic                    sd_ack,
   input  logic                    sd_buff_wr,
   output logic [7:0]              sd_buff_din,
   output logic [1:0]              sd_drive,
   output logic [NDRIVES-1:0]      grant,

   input  logic [NDRIVES-1:0]      disk_change,
   input  logic [NDRIVES-1:0]      disk_readonly,
   output logic [NDRIVES-1:0]      drv_wps_n
);

   localparam logic [23:0] ChgHold = 24'(CHG_HOLD);
   localparam logic [1:0]  RrInit  = 2'(NDRIVES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StXfer,
      StDone,
      StFlush
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          owner_q, owner_d;
   logic [1:0]          rr_q, rr_d;
   logic [1:0]          sd_drive_q, sd_drive_d;
   logic [NDRIVES-1:0]  grant_q, grant_d;
   logic [31:0]         sd_lba_q, sd_lba_d;
   logic                sd_rd_q, sd_rd_d;
   logic                sd_wr_q, sd_wr_d;

   logic [NDRIVES-1:0]  pending;
   logic                found;
   logic [1:0]          win;

   assign pending = drv_rd | drv_wr;

   // First pending channel after the last owner, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= int'(NDRIVES); k++) begin
         if (!found && pending[(int'(rr_q) + k) % int'(NDRIVES)]) begin
            found = 1'b1;
            win   = 2'((int'(rr_q) + k) % int'(NDRIVES));
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_d       = rr_q;
      sd_drive_d = sd_drive_q;
      grant_d    = grant_q;
      sd_lba_d   = sd_lba_q;
      sd_rd_d    = sd_rd_q;
      sd_wr_d    = sd_wr_q;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               owner_d      = win;
               sd_drive_d   = win;
               grant_d      = '0;
               grant_d[win] = 1'b1;
               sd_lba_d     = drv_lba[32*int'(win) +: 32];
               if (drv_wr[win]) begin
                  sd_wr_d = 1'b1;
               end else begin
                  sd_rd_d = 1'b1;
               end
               state_d = StReq;
            end
         end
         StReq: begin
            if (sd_ack) begin
               sd_rd_d = 1'b0;
               sd_wr_d = 1'b0;
               state_d = StXfer;
            end
         end
         StXfer: begin
            if (!sd_ack) begin
               grant_d = '0;
               rr_d    = owner_q;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         StFlush: begin
            // A host transfer interrupted by reset must drain before anyone is granted.
            if (!sd_ack) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= sd_ack ? StFlush : StIdle;
         owner_q    <= '0;
         rr_q       <= RrInit;
         sd_drive_q <= '0;
         grant_q    <= '0;
         sd_lba_q   <= '0;
         sd_rd_q    <= 1'b0;
         sd_wr_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_q       <= rr_d;
         sd_drive_q <= sd_drive_d;
         grant_q    <= grant_d;
         sd_lba_q   <= sd_lba_d;
         sd_rd_q    <= sd_rd_d;
         sd_wr_q    <= sd_wr_d;
      end
   end

   // Buffer path is purely combinational; grant gates it so idle slots see zero.
   assign drv_ack     = grant_q & {NDRIVES{sd_ack}};
   assign drv_buff_wr = grant_q & {NDRIVES{sd_buff_wr}};
   assign sd_buff_din = (|grant_q) ? drv_buff_din[8*int'(owner_q) +: 8] : 8'h00;

   assign sd_lba   = sd_lba_q;
   assign sd_rd    = sd_rd_q;
   assign sd_wr    = sd_wr_q;
   assign sd_drive = sd_drive_q;
   assign grant    = grant_q;

   logic [NDRIVES-1:0] chg_prev_q;
   logic [NDRIVES-1:0] ro_q;
   logic [NDRIVES-1:0] ch_q;
   logic [23:0]        cnt_q [NDRIVES];
   logic [NDRIVES-1:0] chg_rise;

   assign chg_rise = disk_change & ~chg_prev_q;

   always_ff @(posedge clk_sys) begin
      chg_prev_q <= disk_change;
   end

   // Read-only state belongs to the mounted image, so reset leaves it alone.
   always_ff @(posedge clk_sys) begin
      for (int i = 0; i < int'(NDRIVES); i++) begin
         if (chg_rise[i]) begin
            ro_q[i] <= disk_readonly[i];
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         for (int i = 0; i < int'(NDRIVES); i++) begin
            cnt_q[i] <= '0;
         end
         ch_q <= '0;
      end else begin
         for (int i = 0; i < int'(NDRIVES); i++) begin
            if (chg_rise[i]) begin
               cnt_q[i] <= ChgHold;
            end else if (cnt_q[i] != '0) begin
               cnt_q[i] <= cnt_q[i] - 24'd1;
            end
            ch_q[i] <= (cnt_q[i] != '0);
         end
      end
   end

   assign drv_wps_n = ~ro_q ^ ch_q;

endmodule

// File: tb/tb_c15xx_sd_arbiter.sv
// Randomised bench for c15xx_sd_arbiter: a host/drive emulation checked against
// a round-robin pick model and a time-window model of the change pulse.
module tb_c15xx_sd_arbiter;

   localparam int N    = 4;
   localparam int HOLD = 10;

   logic              clk_sys = 1'b0;
   logic              reset;
   logic [32*N-1:0]   drv_lba;
   logic [N-1:0]      drv_rd;
   logic [N-1:0]      drv_wr;
   logic [N-1:0]      drv_ack;
   logic [N-1:0]      drv_buff_wr;
   logic [8*N-1:0]    drv_buff_din;
   logic [31:0]       sd_lba;
   logic              sd_rd;
   logic              sd_wr;
   logic              sd_ack;
   logic              sd_buff_wr;
   logic [7:0]        sd_buff_din;
   logic [1:0]        sd_drive;
   logic [N-1:0]      grant;
   logic [N-1:0]      disk_change;
   logic [N-1:0]      disk_readonly;
   logic [N-1:0]      drv_wps_n;

   c15xx_sd_arbiter #(
      .NDRIVES  (N),
      .CHG_HOLD (HOLD)
   ) dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .drv_lba       (drv_lba),
      .drv_rd        (drv_rd),
      .drv_wr        (drv_wr),
      .drv_ack       (drv_ack),
      .drv_buff_wr   (drv_buff_wr),
      .drv_buff_din  (drv_buff_din),
      .sd_lba        (sd_lba),
      .sd_rd         (sd_rd),
      .sd_wr         (sd_wr),
      .sd_ack        (sd_ack),
      .sd_buff_wr    (sd_buff_wr),
      .sd_buff_din   (sd_buff_din),
      .sd_drive      (sd_drive),
      .grant         (grant),
      .disk_change   (disk_change),
      .disk_readonly (disk_readonly),
      .drv_wps_n     (drv_wps_n)
   );

   always #5 clk_sys = ~clk_sys;

   int checks   = 0;
   int failures = 0;
   int rr_m;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_sys);
   endtask

   // Round-robin rule: scan from the channel after the last owner.
   function automatic int pick(input logic [N-1:0] pend, input int rr);
      for (int k = 1; k <= N; k++) begin
         if (pend[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic in_pulse(input int j, input int r);
      return (j >= r + 2) && (j <= r + HOLD + 1);
   endfunction

   task automatic set_req(input int d, input logic rd, input logic wr, input logic [31:0] lba);
      drv_rd[d] = rd;
      drv_wr[d] = wr;
      drv_lba[32*d +: 32] = lba;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      rr_m  = N - 1;
   endtask

   // One full host transaction; returns the sd_drive the DUT presented.
   task automatic do_xfer(input int npulses, input int ack_delay, input logic [N-1:0] rereq,
                          input logic din_rand, input logic [7:0] din_byte, output int seen_drive);
      logic [N-1:0] pend;
      logic [N-1:0] oh;
      logic [31:0]  exp_lba;
      logic         exp_wr;
      int           w;
      int           cyc;
      int           seen;
      pend = drv_rd | drv_wr;
      w    = pick(pend, rr_m);
      seen_drive = -1;
      if (w < 0) begin
         check_eq("no_pending", 32'd0, 32'd1);
         return;
      end
      exp_wr  = drv_wr[w];
      exp_lba = drv_lba[32*w +: 32];
      oh      = '0;
      oh[w]   = 1'b1;
      cyc = 0;
      while (!(sd_rd || sd_wr) && cyc < 10) begin
         tick();
         cyc++;
      end
      check_eq("req_seen", {31'd0, sd_rd | sd_wr}, 32'd1);
      if (!(sd_rd || sd_wr)) return;
      seen_drive = int'(sd_drive);
      check_eq("grant", {28'd0, grant}, {28'd0, oh});
      check_eq("sd_drive", {30'd0, sd_drive}, w);
      check_eq("sd_lba", sd_lba, exp_lba);
      check_eq("sd_wr", {31'd0, sd_wr}, {31'd0, exp_wr});
      check_eq("sd_rd", {31'd0, sd_rd}, {31'd0, ~exp_wr});
      repeat (ack_delay) tick();
      check_eq("req_hold", {30'd0, sd_rd, sd_wr}, {30'd0, ~exp_wr, exp_wr});
      check_eq("lba_hold", sd_lba, exp_lba);
      sd_ack = 1'b1;
      drv_rd[w] = 1'b0;
      drv_wr[w] = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (rereq[i] && !(drv_rd[i] || drv_wr[i])) begin
            case ($urandom_range(0, 2))
               0:       set_req(i, 1'b1, 1'b0, $urandom);
               1:       set_req(i, 1'b0, 1'b1, $urandom);
               default: set_req(i, 1'b1, 1'b1, $urandom);
            endcase
         end
      end
      #1;
      check_eq("ack_route", {28'd0, drv_ack}, {28'd0, oh});
      tick();
      check_eq("req_clear", {30'd0, sd_rd, sd_wr}, 32'd0);
      check_eq("grant_xfer", {28'd0, grant}, {28'd0, oh});
      seen = 0;
      for (int p = 0; p < npulses; p++) begin
         drv_buff_din = $urandom;
         if (!din_rand) drv_buff_din[8*w +: 8] = din_byte;
         sd_buff_wr = 1'b1;
         #1;
         check_eq("buff_wr_route", {28'd0, drv_buff_wr}, {28'd0, oh});
         check_eq("buff_din", {24'd0, sd_buff_din}, {24'd0, drv_buff_din[8*w +: 8]});
         if (drv_buff_wr[w]) seen++;
         tick();
         sd_buff_wr = 1'b0;
         #1;
         check_eq("buff_wr_low", {28'd0, drv_buff_wr}, 32'd0);
         tick();
      end
      check_eq("pulse_count", seen, npulses);
      sd_ack = 1'b0;
      #1;
      check_eq("ack_low", {28'd0, drv_ack}, 32'd0);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (grant != '0 && cyc < 3);
      check_eq("grant_release", {28'd0, grant}, 32'd0);
      check_eq("idle_din", {24'd0, sd_buff_din}, 32'd0);
      rr_m = w;
   endtask

   int   exp_order [5] = '{0, 1, 2, 3, 0};
   int   sd_seen;
   int   cyc;
   logic exp0;
   logic exp1;

   initial begin
      reset         = 1'b1;
      drv_lba       = '0;
      drv_rd        = '0;
      drv_wr        = '0;
      drv_buff_din  = '0;
      sd_ack        = 1'b0;
      sd_buff_wr    = 1'b0;
      disk_change   = '0;
      disk_readonly = '0;
      rr_m          = N - 1;
      repeat (3) tick();
      check_eq("rst_sd_rd", {31'd0, sd_rd}, 32'd0);
      check_eq("rst_sd_wr", {31'd0, sd_wr}, 32'd0);
      check_eq("rst_lba", sd_lba, 32'd0);
      check_eq("rst_grant", {28'd0, grant}, 32'd0);
      check_eq("rst_drive", {30'd0, sd_drive}, 32'd0);
      check_eq("rst_ack", {28'd0, drv_ack}, 32'd0);
      check_eq("rst_bwr", {28'd0, drv_buff_wr}, 32'd0);
      reset = 1'b0;
      tick();

      // Single read on drive 2: one-cycle request latency, then a full 512-byte sector.
      set_req(2, 1'b1, 1'b0, 32'h123);
      #1;
      check_eq("lat_early", {31'd0, sd_rd}, 32'd0);
      tick();
      check_eq("lat_rd", {31'd0, sd_rd}, 32'd1);
      check_eq("lat_grant", {28'd0, grant}, 32'h4);
      do_xfer(512, 1, '0, 1'b1, 8'h00, sd_seen);

      // Round robin from reset, with drive 0 re-requesting during drive 1's transfer.
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'h1000 + i);
      for (int k = 0; k < 5; k++) begin
         do_xfer(2, k % 2, (k == 1) ? 4'b0001 : 4'b0000, 1'b1, 8'h00, sd_seen);
         check_eq("rr_order", sd_seen, exp_order[k]);
      end

      // Write path with a fixed data byte, then rd+wr together on one drive.
      set_req(1, 1'b0, 1'b1, 32'hCAFE);
      do_xfer(4, 0, '0, 1'b0, 8'hA5, sd_seen);
      set_req(3, 1'b1, 1'b1, 32'h5555);
      do_xfer(1, 2, '0, 1'b1, 8'h00, sd_seen);

      // Random traffic.
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!(drv_rd[i] || drv_wr[i]) && $urandom_range(0, 1) == 1) begin
               set_req(i, 1'($urandom_range(0, 1)), 1'b1, $urandom);
               if ($urandom_range(0, 1) == 1) drv_wr[i] = 1'b0;
               drv_rd[i] = drv_rd[i] | ~drv_wr[i];
            end
         end
         if ((drv_rd | drv_wr) == '0) set_req($urandom_range(0, N - 1), 1'b1, 1'b0, $urandom);
         do_xfer($urandom_range(0, 6), $urandom_range(0, 3), 4'($urandom_range(0, 15)),
                 1'b1, 8'h00, sd_seen);
      end

      // Reset while the host is mid-transfer with ack high.
      drv_rd = '0;
      drv_wr = '0;
      tick();
      tick();
      set_req(0, 1'b1, 1'b0, 32'h77);
      cyc = 0;
      while (!sd_rd && cyc < 10) begin
         tick();
         cyc++;
      end
      check_eq("rx_req", {31'd0, sd_rd}, 32'd1);
      sd_ack = 1'b1;
      drv_rd[0] = 1'b0;
      set_req(3, 1'b1, 1'b0, 32'hBEEF);
      tick();
      sd_buff_wr = 1'b1;
      tick();
      sd_buff_wr = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rr_m  = N - 1;
      check_eq("rx_sd_rd", {31'd0, sd_rd}, 32'd0);
      check_eq("rx_sd_wr", {31'd0, sd_wr}, 32'd0);
      check_eq("rx_grant", {28'd0, grant}, 32'd0);
      check_eq("rx_ack", {28'd0, drv_ack}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("flush_block", {28'd0, grant}, 32'd0);
      end
      sd_ack = 1'b0;
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (grant == '0 && cyc < 4);
      check_eq("flush_grant", {28'd0, grant}, 32'h8);
      do_xfer(1, 0, '0, 1'b1, 8'h00, sd_seen);

      // Change hold: drive 0 read-only with a re-trigger, drive 1 writable single pulse.
      disk_readonly = 4'b0001;
      disk_change   = 4'b0011;
      for (int j = 1; j <= 30; j++) begin
         tick();
         exp0 = in_pulse(j, 0) || in_pulse(j, 5);
         exp1 = in_pulse(j, 0);
         check_eq($sformatf("wps0_j%0d", j), {31'd0, drv_wps_n[0]}, {31'd0, exp0});
         check_eq($sformatf("wps1_j%0d", j), {31'd0, drv_wps_n[1]}, {31'd0, ~exp1});
         if (j == 3) disk_change[0] = 1'b0;
         if (j == 5) disk_change[0] = 1'b1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
